palm_locator: RTL and testbench



---
 rtl/gesture_pkg.sv | 16 +
 rtl/row_run_stats.sv | 51 +++++
 rtl/palm_locator.sv | 179 +++++++++++++++++
 tb/tb_palm_locator.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/gesture_pkg.sv
// Shared definitions for the palm locator and the finger-identification stage.
package gesture_pkg;

    localparam int COORD_W          = 10;
    localparam int RCNT_W           = 8;
    localparam int DEF_IMAGE_WIDTH  = 120;
    localparam int DEF_IMAGE_HEIGHT = 160;

    typedef logic [COORD_W-1:0] coord_t;

    typedef enum logic {
        SCAN    = 1'b0,
        PUBLISH = 1'b1
    } palm_state_t;

endpackage

// File: rtl/row_run_stats.sv
// Per-row white-pixel accumulator. Outputs are the row statistics including
// the pixel presented this cycle, so a row can be closed on its last pixel.
module row_run_stats
    import gesture_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              de_t,
    input  logic              object_image,
    input  logic [COORD_W-1:0] col,
    input  logic              row_start,
    output logic [RCNT_W-1:0] rcnt,
    output logic [COORD_W-1:0] rmin,
    output logic [COORD_W-1:0] rmax
);

    logic [RCNT_W-1:0] cnt_q, cnt_base;
    coord_t            min_q, max_q, min_base, max_base;
    logic              hit;

    always_comb begin
        cnt_base = row_start ? '0 : cnt_q;
        min_base = row_start ? '0 : min_q;
        max_base = row_start ? '0 : max_q;
        hit      = de_t && object_image;
        rcnt     = cnt_base;
        rmin     = min_base;
        rmax     = max_base;
        if (hit) begin
            if (cnt_base != '1)
                rcnt = cnt_base + 8'd1;
            // An empty row (count 0) takes the first white column as its left edge
            if (cnt_base == '0 || col < min_base)
                rmin = col;
            rmax = col;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
            min_q <= '0;
            max_q <= '0;
        end else if (de_t) begin
            cnt_q <= rcnt;
            min_q <= rmin;
            max_q <= rmax;
        end
    end

endmodule

// File: rtl/palm_locator.sv
// Streaming palm bounding-box extractor: qualifies rows by white count and
// publishes the per-frame box of qualifying rows one cycle after frame end.
module palm_locator
    import gesture_pkg::*;
#(
    parameter int IMAGE_WIDTH  = DEF_IMAGE_WIDTH,
    parameter int IMAGE_HEIGHT = DEF_IMAGE_HEIGHT,
    parameter int ROW_MIN_PIX  = 8,
    parameter int MIN_ROWS     = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               de_t,
    input  logic               object_image,
    output logic [COORD_W-1:0] palm_width,
    output logic [COORD_W-1:0] palm_height,
    output logic [COORD_W-1:0] start_of_palm_r,
    output logic [COORD_W-1:0] start_of_palm_c,
    output logic [COORD_W-1:0] end_of_palm_r,
    output logic [COORD_W-1:0] end_of_palm_c,
    output logic               frame_done
);

    localparam coord_t            LAST_COL = coord_t'(IMAGE_WIDTH - 1);
    localparam coord_t            LAST_ROW = coord_t'(IMAGE_HEIGHT - 1);
    localparam logic [RCNT_W-1:0] ROW_MIN  = RCNT_W'(ROW_MIN_PIX);
    localparam logic [7:0]        ROWS_MIN = 8'(MIN_ROWS);

    coord_t            col, row, rmin, rmax;
    logic [RCNT_W-1:0] rcnt;
    logic              last_col, frame_close, row_qual;

    coord_t     fmin_c, fmax_c, fmin_r, fmax_r, m_min_c, m_max_c, m_min_r, m_max_r;
    logic [7:0] nrows, m_nrows;

    coord_t     min_c_p1, max_c_p1, min_r_p1, max_r_p1;
    logic [7:0] nrows_p1;

    palm_state_t state_q, state_d;
    logic        publish;

    assign last_col    = (col == LAST_COL);
    assign frame_close = de_t && last_col && (row == LAST_ROW);
    assign row_qual    = de_t && last_col && (rcnt >= ROW_MIN);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (de_t) begin
            if (last_col) begin
                col <= '0;
                row <= (row == LAST_ROW) ? '0 : row + 10'd1;
            end else begin
                col <= col + 10'd1;
            end
        end
    end

    row_run_stats u_row_stats (
        .clk          (clk),
        .rst_n        (rst_n),
        .de_t         (de_t),
        .object_image (object_image),
        .col          (col),
        .row_start    (col == '0),
        .rcnt         (rcnt),
        .rmin         (rmin),
        .rmax         (rmax)
    );

    // Frame accumulators merged with the row closing this cycle
    always_comb begin
        m_min_c = fmin_c;
        m_max_c = fmax_c;
        m_min_r = fmin_r;
        m_max_r = fmax_r;
        m_nrows = nrows;
        if (row_qual) begin
            if (nrows == '0) begin
                m_min_c = rmin;
                m_max_c = rmax;
                m_min_r = row;
            end else begin
                m_min_c = (rmin < fmin_c) ? rmin : fmin_c;
                m_max_c = (rmax > fmax_c) ? rmax : fmax_c;
            end
            m_max_r = row;
            if (nrows != '1)
                m_nrows = nrows + 8'd1;
        end
    end

    // Stage 1: frame accumulators and staging of the closed frame
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fmin_c   <= '0;
            fmax_c   <= '0;
            fmin_r   <= '0;
            fmax_r   <= '0;
            nrows    <= '0;
            min_c_p1 <= '0;
            max_c_p1 <= '0;
            min_r_p1 <= '0;
            max_r_p1 <= '0;
            nrows_p1 <= '0;
        end else if (frame_close) begin
            min_c_p1 <= m_min_c;
            max_c_p1 <= m_max_c;
            min_r_p1 <= m_min_r;
            max_r_p1 <= m_max_r;
            nrows_p1 <= m_nrows;
            fmin_c   <= '0;
            fmax_c   <= '0;
            fmin_r   <= '0;
            fmax_r   <= '0;
            nrows    <= '0;
        end else if (row_qual) begin
            fmin_c <= m_min_c;
            fmax_c <= m_max_c;
            fmin_r <= m_min_r;
            fmax_r <= m_max_r;
            nrows  <= m_nrows;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            state_q <= SCAN;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            SCAN:    if (frame_close) state_d = PUBLISH;
            PUBLISH: state_d = SCAN;
            default: state_d = SCAN;
        endcase
    end

    always_comb begin
        publish = (state_q == PUBLISH);
    end

    // Stage 2: published outputs, held until the next frame
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_done      <= 1'b0;
            palm_width      <= '0;
            palm_height     <= '0;
            start_of_palm_r <= '0;
            start_of_palm_c <= '0;
            end_of_palm_r   <= '0;
            end_of_palm_c   <= '0;
        end else begin
            frame_done <= publish;
            if (publish) begin
                if (nrows_p1 >= ROWS_MIN) begin
                    palm_width      <= max_c_p1 - min_c_p1 + 10'd1;
                    palm_height     <= max_r_p1 - min_r_p1 + 10'd1;
                    start_of_palm_r <= min_r_p1;
                    start_of_palm_c <= min_c_p1;
                    end_of_palm_r   <= max_r_p1;
                    end_of_palm_c   <= max_c_p1;
                end else begin
                    palm_width      <= '0;
                    palm_height     <= '0;
                    start_of_palm_r <= '0;
                    start_of_palm_c <= '0;
                    end_of_palm_r   <= '0;
                    end_of_palm_c   <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_palm_locator.sv
// Scoreboard bench for palm_locator: a whole-frame image model predicts each
// published box, and every frame_done pulse is matched against it.
module tb_palm_locator;
    import gesture_pkg::*;

    localparam int W        = 72;
    localparam int H        = 104;
    localparam int ROW_MIN  = 8;
    localparam int MIN_ROWS = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       de_t = 1'b0;
    logic       object_image = 1'b0;
    logic [9:0] palm_width, palm_height;
    logic [9:0] start_of_palm_r, start_of_palm_c, end_of_palm_r, end_of_palm_c;
    logic       frame_done;

    always #5 clk = ~clk;

    palm_locator #(
        .IMAGE_WIDTH  (W),
        .IMAGE_HEIGHT (H),
        .ROW_MIN_PIX  (ROW_MIN),
        .MIN_ROWS     (MIN_ROWS)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .de_t            (de_t),
        .object_image    (object_image),
        .palm_width      (palm_width),
        .palm_height     (palm_height),
        .start_of_palm_r (start_of_palm_r),
        .start_of_palm_c (start_of_palm_c),
        .end_of_palm_r   (end_of_palm_r),
        .end_of_palm_c   (end_of_palm_c),
        .frame_done      (frame_done)
    );

    typedef struct {
        logic [9:0] w, h, sr, sc, er, ec;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    bit   img [H][W];
    bit   skip = 1'b1;
    bit   expect_low = 1'b0;
    logic [59:0] held = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, expv, $time);
        end
    endtask

    task automatic clear_img();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                img[r][c] = 1'b0;
    endtask

    task automatic fill_rect(input int r0, input int r1, input int c0, input int c1);
        for (int r = r0; r <= r1; r++)
            for (int c = c0; c <= c1; c++)
                img[r][c] = 1'b1;
    endtask

    function automatic exp_t model();
        exp_t e;
        int nq, sr, er, sc, ec;
        nq = 0; sr = 0; er = 0; sc = W; ec = 0;
        for (int r = 0; r < H; r++) begin
            int cnt, lo, hi;
            cnt = 0; lo = W; hi = 0;
            for (int c = 0; c < W; c++)
                if (img[r][c]) begin
                    cnt++;
                    if (c < lo) lo = c;
                    hi = c;
                end
            if (cnt >= ROW_MIN) begin
                if (nq == 0) sr = r;
                er = r;
                if (lo < sc) sc = lo;
                if (hi > ec) ec = hi;
                nq++;
            end
        end
        e = '{w: '0, h: '0, sr: '0, sc: '0, er: '0, ec: '0, cyc: 0};
        if (nq >= MIN_ROWS) begin
            e.sr = 10'(sr); e.er = 10'(er);
            e.sc = 10'(sc); e.ec = 10'(ec);
            e.w  = 10'(ec - sc + 1);
            e.h  = 10'(er - sr + 1);
        end
        return e;
    endfunction

    task automatic drive(input logic d, input logic p);
        @(posedge clk);
        #1;
        de_t = d;
        object_image = p;
    endtask

    // Streams img rows [0, stop_row); a full frame pushes its expected result
    task automatic send_frame(input int gap_pct, input int stop_row);
        exp_t e;
        for (int r = 0; r < stop_row; r++)
            for (int c = 0; c < W; c++) begin
                if (!(r == 0 && c == 0))
                    while (int'($urandom_range(0, 99)) < gap_pct)
                        drive(1'b0, 1'($urandom_range(0, 1)));
                drive(1'b1, img[r][c]);
                if (r == H - 1 && c == W - 1) begin
                    e = model();
                    e.cyc = cyc + 2;
                    exp_q.push_back(e);
                end
            end
    endtask

    task automatic check_reset_state();
        check_eq("rst_width",   64'(palm_width), 64'd0);
        check_eq("rst_height",  64'(palm_height), 64'd0);
        check_eq("rst_start_r", 64'(start_of_palm_r), 64'd0);
        check_eq("rst_start_c", 64'(start_of_palm_c), 64'd0);
        check_eq("rst_end_r",   64'(end_of_palm_r), 64'd0);
        check_eq("rst_end_c",   64'(end_of_palm_c), 64'd0);
        check_eq("rst_done",    64'(frame_done), 64'd0);
    endtask

    task automatic apply_reset();
        skip = 1'b1;
        @(posedge clk);
        #1;
        de_t = 1'b0;
        object_image = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_reset_state();
        skip = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (skip) begin
            held = '0;
            expect_low = 1'b0;
        end else if (frame_done && !expect_low) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_done", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check_eq("latency", 64'(cyc), 64'(e.cyc));
                check_eq("width",   64'(palm_width), 64'(e.w));
                check_eq("height",  64'(palm_height), 64'(e.h));
                check_eq("start_r", 64'(start_of_palm_r), 64'(e.sr));
                check_eq("start_c", 64'(start_of_palm_c), 64'(e.sc));
                check_eq("end_r",   64'(end_of_palm_r), 64'(e.er));
                check_eq("end_c",   64'(end_of_palm_c), 64'(e.ec));
                held = {e.w, e.h, e.sr, e.sc, e.er, e.ec};
            end
            expect_low = 1'b1;
        end else begin
            if (expect_low) begin
                check_eq("done_pulse", 64'(frame_done), 64'd0);
                expect_low = 1'b0;
            end
            check_eq("hold", 64'({palm_width, palm_height, start_of_palm_r,
                                  start_of_palm_c, end_of_palm_r, end_of_palm_c}), 64'(held));
        end
    end

    initial begin
        apply_reset();

        clear_img();
        send_frame(0, H);

        fill_rect(40, 79, 30, 69);
        send_frame(0, H);

        fill_rect(100, 100, 30, 36);
        send_frame(0, H);

        fill_rect(100, 100, 30, 37);
        send_frame(0, H);

        clear_img();
        fill_rect(10, 12, 5, 20);
        send_frame(0, H);

        clear_img();
        fill_rect(H - 4, H - 1, 0, W - 1);
        send_frame(0, H);

        clear_img();
        fill_rect(40, 79, 30, 69);
        send_frame(30, H);
        clear_img();
        send_frame(30, H);

        fill_rect(40, 79, 30, 69);
        send_frame(0, 60);
        apply_reset();
        clear_img();
        send_frame(0, H);

        drive(1'b0, 1'b0);
        for (int i = 0; i < 20 && exp_q.size() != 0; i++)
            @(posedge clk);
        check_eq("drain", 64'(exp_q.size()), 64'd0);
        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
